// File: rtl/xor_stream_cipher_mc_pkg.sv
// ---------------------------------------------------------------------------
// xor_cipher_pkg
// Shared definitions for the multi-channel XOR stream cipher:
//   - parameter limits and the default Galois feedback mask
//   - lfsr_step(): one Galois LFSR step on a zero-extended state
//   - sel_width(): width of a channel-select bus for a given channel count
// ---------------------------------------------------------------------------
package xor_cipher_pkg;

    // Parameter limits for the cipher.
    localparam int M_MIN    = 8;
    localparam int M_MAX    = 64;
    localparam int N_CH_MAX = 8;

    // Default feedback mask (x^32 + x^22 + x^2 + x + 1 style tap set).
    localparam logic [M_MAX-1:0] DEFAULT_POLY = 64'h0000_0000_8020_0003;

    // One Galois step. The state and mask are carried at M_MAX bits with the
    // unused upper bits zero, so the result is valid for any M <= M_MAX.
    function automatic logic [M_MAX-1:0] lfsr_step(
        input logic [M_MAX-1:0] state,
        input logic [M_MAX-1:0] poly
    );
        return (state >> 1) ^ (state[0] ? poly : '0);
    endfunction

    // A single channel still gets a 1-bit select so the port never vanishes.
    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/xor_stream_cipher_mc_lfsr_ch.sv
// ---------------------------------------------------------------------------
// xor_lfsr_ch
// One cipher channel: an M-bit slice of the serial seed chain, the channel's
// Galois LFSR, and the W-step keystream/advance logic.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   shift_en     shift the seed slice one bit (seed chain clock enable)
//   shift_in     serial bit entering bit 0 of this slice
//   shift_out    MSB of this slice (feeds the next channel / cfg_o)
//   load         copy seed into the LFSR (a zero seed loads 1)
//   advance      step the LFSR W times (one accepted beat)
//   ks           keystream for the current beat, bit i = state[0] before step i
// ---------------------------------------------------------------------------
module xor_lfsr_ch
    import xor_cipher_pkg::*;
#(
    parameter int          M    = 32,
    parameter int          W    = 1,
    parameter logic [M-1:0] POLY = M'(DEFAULT_POLY)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         shift_in,
    output logic         shift_out,
    input  logic         load,
    input  logic         advance,
    output logic [W-1:0] ks
);

    logic [M-1:0]     seed_q;
    logic [M-1:0]     state_q;
    logic [M-1:0]     state_adv;
    logic [M-1:0]     seed_eff;
    logic [M_MAX-1:0] walk;

    // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
    assign seed_eff  = (seed_q == '0) ? M'(1) : seed_q;
    assign shift_out = seed_q[M-1];

    // Unroll W Galois steps: collect the keystream bits on the way and keep
    // the final state for the advance.
    // NOTE: every variable written here gets a value before any branch or
    // loop so the block stays purely combinational and infers no latch.
    always_comb begin
        walk = M_MAX'(state_q);
        ks   = '0;
        for (int i = 0; i < W; i++) begin
            ks[i] = walk[0];
            walk  = lfsr_step(walk, M_MAX'(POLY));
        end
    end

    assign state_adv = walk[M-1:0];

    // The upper bits of the widened walk stay zero by construction.
    if (M < M_MAX) begin : g_walk_hi
        logic unused_walk_hi;
        assign unused_walk_hi = |walk[M_MAX-1:M];
    end

    // NOTE: all state here updates with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    // NOTE: seed and LFSR are ordinary flops with a defined reset value; the
    // first beat after reset must see state 1 on every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q  <= '0;
            state_q <= M'(1);
        end else begin
            if (shift_en) begin
                seed_q <= {seed_q[M-2:0], shift_in};
            end
            if (load) begin
                state_q <= seed_eff;
            end else if (advance) begin
                state_q <= state_adv;
            end
        end
    end

endmodule

// File: rtl/xor_stream_cipher_mc.sv
// ---------------------------------------------------------------------------
// xor_stream_cipher_mc
// Multi-channel XOR stream cipher. Each channel owns a seed register (all of
// them chained into one serial configuration shift register) and a Galois
// LFSR that produces W keystream bits per accepted beat. A beat on channel
// ch_sel is XORed with that channel's keystream and registered (latency 1,
// one beat per cycle). Encryption and decryption are the same operation.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cfg_en, cfg_i, cfg_o    seed-chain shift enable, serial in, serial out
//   ch_sel                  channel for the current beat or resync
//   in_valid/in_ready/in_data     input beat handshake
//   out_valid/out_ready/out_data  output beat handshake
//   resync                  reload channel ch_sel's LFSR from its seed
//   heartbeat               slow free-running liveness count
// ---------------------------------------------------------------------------
module xor_stream_cipher_mc
    import xor_cipher_pkg::*;
#(
    parameter int           M      = 32,
    parameter int           N_CH   = 2,
    parameter int           W      = 1,
    parameter logic [M-1:0] POLY   = M'(DEFAULT_POLY),
    parameter int           HB_DIV = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_en,
    input  logic                         cfg_i,
    output logic                         cfg_o,
    input  logic [sel_width(N_CH)-1:0]   ch_sel,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    input  logic                         resync,
    output logic [2:0]                   heartbeat
);

    logic              load_pending;
    logic              ch_ok;
    logic              accept;
    logic              resync_fire;
    logic              load_all;
    logic [N_CH:0]     chain;
    logic [W-1:0]      ks [N_CH];
    logic [W-1:0]      ks_sel;
    logic [HB_DIV+2:0] hb_cnt;

    // An out-of-range channel select simply stalls the input.
    assign ch_ok = (int'(ch_sel) < N_CH);

    // Inputs are refused while configuring, during the reload cycle that
    // follows configuration, during a resync, and while the output register
    // holds a beat that is not leaving this cycle.
    assign in_ready    = !cfg_en && !load_pending && !resync && ch_ok
                         && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign resync_fire = resync && !cfg_en && ch_ok;
    assign load_all    = load_pending && !cfg_en;

    // Seed chain: cfg_i enters channel 0, each channel's MSB feeds the next.
    assign chain[0] = cfg_i;
    assign cfg_o    = chain[N_CH];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic hit;
        assign hit = (int'(ch_sel) == c);

        xor_lfsr_ch #(
            .M    (M),
            .W    (W),
            .POLY (POLY)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .shift_en  (cfg_en),
            .shift_in  (chain[c]),
            .shift_out (chain[c+1]),
            .load      (load_all || (resync_fire && hit)),
            .advance   (accept && hit),
            .ks        (ks[c])
        );
    end

    always_comb begin
        ks_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (int'(ch_sel) == c) begin
                ks_sel = ks[c];
            end
        end
    end

    // load_pending marks the single cycle after cfg_en drops, in which every
    // LFSR takes its freshly shifted seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_pending <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            hb_cnt       <= '0;
        end else begin
            load_pending <= cfg_en;
            hb_cnt       <= hb_cnt + 1'b1;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data ^ ks_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign heartbeat = hb_cnt[HB_DIV+2:HB_DIV];

endmodule

// File: tb/tb_xor_stream_cipher_mc.sv
// ---------------------------------------------------------------------------
// tb_xor_stream_cipher_mc
// Self-checking bench for xor_stream_cipher_mc (M=32, N_CH=2, W=1).
// Reference: per-channel LFSR states and a 64-bit seed chain held as plain
// variables, stepped with the textbook Galois rule.
// ---------------------------------------------------------------------------
module tb_xor_stream_cipher_mc;

    localparam int          M      = 32;
    localparam int          N_CH   = 2;
    localparam int          W      = 1;
    localparam int          HB_DIV = 2;
    localparam logic [31:0] POLY   = 32'h8020_0003;
    localparam int          N_RT   = 1000;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         cfg_en    = 1'b0;
    logic         cfg_i     = 1'b0;
    logic         cfg_o;
    logic [0:0]   ch_sel    = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data   = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         resync    = 1'b0;
    logic [2:0]   heartbeat;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_hi  = 0;

    // Reference model state.
    logic [31:0] st [2];
    logic [63:0] chain;
    logic        mv, md, lp;

    typedef struct {
        int   ch;
        logic data;
        logic exp;
    } vec_t;
    vec_t vecs [7];

    logic pt [N_RT];
    logic ct [N_RT];
    int   chs [N_RT];

    always #5 clk = ~clk;

    xor_stream_cipher_mc #(
        .M      (M),
        .N_CH   (N_CH),
        .W      (W),
        .POLY   (POLY),
        .HB_DIV (HB_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .cfg_i     (cfg_i),
        .cfg_o     (cfg_o),
        .ch_sel    (ch_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .resync    (resync),
        .heartbeat (heartbeat)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] seed_or_one(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    task automatic model_ks(input int ch, output logic k);
        k      = st[ch][0];
        st[ch] = lfsr_next(st[ch]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        cfg_en    = 1'b0;
        cfg_i     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        resync    = 1'b0;
        ch_sel    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chain = '0;
        st[0] = 32'h1;
        st[1] = 32'h1;
        mv    = 1'b0;
        md    = 1'b0;
        lp    = 1'b0;
    endtask

    // One beat with out_ready high; checks the registered result next cycle.
    task automatic beat(input int ch, input logic d, input logic exp,
                        input string nm, output logic got);
        ch_sel    = 1'(ch);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        resync    = 1'b0;
        cfg_en    = 1'b0;
        #1;
        check({nm, " in_ready"}, 64'(in_ready), 64'(1'b1));
        tick();
        check({nm, " out_valid"}, 64'(out_valid), 64'(1'b1));
        check({nm, " out_data"}, 64'(out_data), 64'(exp));
        got      = out_data[0];
        in_valid = 1'b0;
    endtask

    task automatic mbeat(input int ch, input logic d, input string nm);
        logic k, got;
        model_ks(ch, k);
        beat(ch, d, d ^ k, nm, got);
    endtask

    // Shift 64 bits MSB first; counts any cycle where in_ready is seen high.
    task automatic shift_bits(input logic [63:0] w);
        for (int i = 63; i >= 0; i--) begin
            cfg_en   = 1'b1;
            cfg_i    = w[i];
            in_valid = 1'b1;
            #1;
            if (in_ready) rdy_hi++;
            tick();
            chain = {chain[62:0], w[i]};
        end
    endtask

    task automatic load_cycle();
        cfg_en = 1'b0;
        cfg_i  = 1'b0;
        #1;
        if (in_ready) rdy_hi++;
        tick();
        in_valid = 1'b0;
        st[0] = seed_or_one(chain[31:0]);
        st[1] = seed_or_one(chain[63:32]);
    endtask

    task automatic do_resync(input int ch);
        resync    = 1'b1;
        ch_sel    = 1'(ch);
        in_valid  = 1'b1;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        check("resync in_ready", 64'(in_ready), 64'(1'b0));
        tick();
        check("resync no accept", 64'(out_valid), 64'(1'b0));
        resync   = 1'b0;
        in_valid = 1'b0;
        st[ch]   = seed_or_one(ch == 0 ? chain[31:0] : chain[63:32]);
    endtask

    initial begin
        logic        k, got, er, stall_bad;
        logic        exp0 [4];
        logic [63:0] cap, rnd_seed;
        int          burst, ch, bad;

        vecs[0] = '{0, 1'b0, 1'b1};
        vecs[1] = '{0, 1'b0, 1'b1};
        vecs[2] = '{0, 1'b0, 1'b0};
        vecs[3] = '{1, 1'b0, 1'b1};
        vecs[4] = '{1, 1'b1, 1'b0};
        vecs[5] = '{1, 1'b1, 1'b1};
        vecs[6] = '{0, 1'b1, 1'b0};

        // Reset values and heartbeat count.
        do_reset();
        check("reset out_valid", 64'(out_valid), 64'(1'b0));
        check("reset out_data", 64'(out_data), 64'(1'b0));
        check("reset cfg_o", 64'(cfg_o), 64'(1'b0));
        check("reset heartbeat", 64'(heartbeat), 64'(3'd0));
        check("reset in_ready", 64'(in_ready), 64'(1'b1));
        bad = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (heartbeat !== 3'((n >> HB_DIV) & 7)) bad++;
        end
        check("heartbeat count/wrap errors", 64'(bad), 64'(0));

        // Table: back-to-back beats from the reset state.
        for (int i = 0; i < 7; i++) begin
            ch_sel    = 1'(vecs[i].ch);
            in_data   = vecs[i].data;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            check($sformatf("tbl[%0d] in_ready", i), 64'(in_ready), 64'(1'b1));
            tick();
            check($sformatf("tbl[%0d] out_valid", i), 64'(out_valid), 64'(1'b1));
            check($sformatf("tbl[%0d] out_data", i), 64'(out_data), 64'(vecs[i].exp));
        end
        in_valid = 1'b0;
        tick();
        check("tbl drain out_valid", 64'(out_valid), 64'(1'b0));

        // Seed chain shift-through and zero-seed load.
        do_reset();
        rdy_hi = 0;
        shift_bits(64'hDEAD_BEEF_0000_0001);
        cap = '0;
        for (int i = 63; i >= 0; i--) begin
            cfg_en = 1'b1;
            cfg_i  = 1'b0;
            cap[i] = cfg_o;
            #1;
            if (in_ready) rdy_hi++;
            tick();
            chain = {chain[62:0], 1'b0};
        end
        check("cfg_o stream", cap, 64'hDEAD_BEEF_0000_0001);
        load_cycle();
        check("in_ready during cfg/load", 64'(rdy_hi), 64'(0));
        beat(1, 1'b0, 1'b1, "zero seed ch1", got);
        beat(0, 1'b0, 1'b1, "zero seed ch0", got);

        // Output back-pressure, then gap-free resume.
        do_reset();
        ch_sel    = 1'b0;
        in_data   = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        check("bp first in_ready", 64'(in_ready), 64'(1'b1));
        model_ks(0, k);
        stall_bad = 1'b1 ^ k;
        tick();
        check("bp first out_data", 64'(out_data), 64'(stall_bad));
        in_data = 1'b0;
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (in_ready !== 1'b0) bad++;
            tick();
            if (out_valid !== 1'b1 || out_data !== stall_bad) bad++;
        end
        check("bp stall errors", 64'(bad), 64'(0));
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("bp resume in_ready", 64'(in_ready), 64'(1'b1));
            model_ks(0, k);
            tick();
            check("bp resume out_valid", 64'(out_valid), 64'(1'b1));
            check("bp resume out_data", 64'(out_data), 64'(k));
        end
        in_valid = 1'b0;
        tick();
        check("bp final drain", 64'(out_valid), 64'(1'b0));

        // cfg_en raised while an output is pending.
        do_reset();
        ch_sel    = 1'b0;
        in_data   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        model_ks(0, k);
        tick();
        check("mid cfg first out_data", 64'(out_data), 64'(k));
        cfg_en = 1'b1;
        cfg_i  = 1'b0;
        #1;
        check("mid cfg in_ready", 64'(in_ready), 64'(1'b0));
        tick();
        chain = {chain[62:0], 1'b0};
        check("mid cfg held", 64'(out_valid), 64'(1'b1));
        out_ready = 1'b1;
        tick();
        chain = {chain[62:0], 1'b0};
        check("mid cfg drained", 64'(out_valid), 64'(1'b0));
        rdy_hi = 0;
        shift_bits(64'h0);
        load_cycle();
        check("mid cfg in_ready low", 64'(rdy_hi), 64'(0));
        mbeat(0, 1'b0, "after reload a");
        mbeat(0, 1'b0, "after reload b");

        // Interleaved channels, then resync of channel 0 only.
        do_reset();
        rdy_hi = 0;
        shift_bits(64'hDEAD_BEEF_1234_5678);
        load_cycle();
        for (int i = 0; i < 8; i++) begin
            ch = i % 2;
            model_ks(ch, k);
            if (ch == 0) exp0[i/2] = k;
            beat(ch, 1'b0, k, "alt pre", got);
        end
        do_resync(0);
        for (int i = 0; i < 8; i++) begin
            ch = i % 2;
            model_ks(ch, k);
            beat(ch, 1'b0, (ch == 0) ? exp0[i/2] : k, (ch == 0) ? "alt ch0 restart" : "alt ch1 cont", got);
        end

        // Asynchronous reset while an output is valid.
        do_reset();
        mbeat(0, 1'b0, "pre reset beat");
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'(1'b0));
        check("async reset out_data", 64'(out_data), 64'(1'b0));
        tick();
        tick();
        rst_n = 1'b1;
        chain = '0;
        st[0] = 32'h1;
        st[1] = 32'h1;
        check("post reset cfg_o", 64'(cfg_o), 64'(1'b0));
        model_ks(0, k);
        beat(0, 1'b0, 1'b1, "post reset ch0", got);

        // Randomised traffic against the reference model.
        do_reset();
        burst = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (burst == 0 && $urandom_range(99) == 0) burst = $urandom_range(70, 1);
            cfg_en = (burst > 0);
            if (burst > 0) burst--;
            cfg_i     = 1'($urandom);
            ch_sel    = 1'($urandom);
            in_valid  = ($urandom_range(9) < 7);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(3) != 0);
            resync    = ($urandom_range(39) == 0);
            ch        = int'(ch_sel);
            #1;
            er = !cfg_en && !lp && !resync && (!mv || out_ready);
            check("rnd in_ready", 64'(in_ready), 64'(er));
            if (cfg_en) chain = {chain[62:0], cfg_i};
            if (in_valid && er) begin
                model_ks(ch, k);
                md = in_data[0] ^ k;
                mv = 1'b1;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            if (!cfg_en && lp) begin
                st[0] = seed_or_one(chain[31:0]);
                st[1] = seed_or_one(chain[63:32]);
            end else if (!cfg_en && resync) begin
                st[ch] = seed_or_one(ch == 0 ? chain[31:0] : chain[63:32]);
            end
            lp = cfg_en;
            tick();
            check("rnd out_valid", 64'(out_valid), 64'(mv));
            if (mv) check("rnd out_data", 64'(out_data), 64'(md));
            check("rnd cfg_o", 64'(cfg_o), 64'(chain[63]));
        end

        // Round trip: encrypt, resync both channels, decrypt the ciphertext.
        do_reset();
        rdy_hi   = 0;
        rnd_seed = {$urandom, $urandom};
        shift_bits(rnd_seed);
        load_cycle();
        for (int i = 0; i < N_RT; i++) begin
            chs[i] = int'($urandom_range(1));
            pt[i]  = 1'($urandom);
            model_ks(chs[i], k);
            beat(chs[i], pt[i], pt[i] ^ k, "enc", got);
            ct[i] = got;
        end
        do_resync(0);
        do_resync(1);
        for (int i = 0; i < N_RT; i++) begin
            beat(chs[i], ct[i], pt[i], "dec", got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_stream_cipher_mc.md
XOR_STREAM_CIPHER_MC -- requirements
Module: xor_stream_cipher_mc

Interface
REQ-001 SHALL have parameter M, 32, LFSR/seed width per channel (8..64).
REQ-002 SHALL have parameter N_CH, 2, channel count (1..8).
REQ-003 SHALL have parameter W, 1, data bits per beat (1..M).
REQ-004 SHALL have parameter POLY, 32'h80200003, Galois feedback mask (M bits).
REQ-005 SHALL have parameter HB_DIV, 20, heartbeat divider exponent.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port cfg_en  in  1  seed-chain shift enable.
REQ-009 SHALL have port cfg_i  in  1  seed-chain serial in; cfg_o  out  1  seed-chain serial out.
REQ-010 SHALL have port ch_sel  in  max(1,$clog2(N_CH))  channel for current beat/resync.
REQ-011 SHALL have port in_valid  in  1, in_ready  out  1, in_data  in  W  input handshake.
REQ-012 SHALL have port out_valid  out  1, out_ready  in  1, out_data  out  W  output handshake.
REQ-013 SHALL have port resync  in  1  reload seed into LFSR of ch_sel.
REQ-014 SHALL have port heartbeat  out  3  liveness indicator.

Function
REQ-015 Seed chain: N_CH*M-bit shift register, one bit per cycle while cfg_en=1; cfg_i enters bit 0 of channel 0; cfg_o = MSB of channel N_CH-1 (registered).
REQ-016 Cycle after cfg_en falls: every channel LFSR loads its seed; zero seed loads 1 (no lock-up).
REQ-017 LFSR step: ks bit = state[0]; next = (state>>1) XOR (state[0] ? POLY : 0).
REQ-018 Beat keystream: bit i of ks = state[0] before step i, i=0..W-1; channel advances exactly W steps per accepted beat; other channels unchanged.
REQ-019 in_ready = !cfg_en && !load_pending && !resync && ch_sel<N_CH && (!out_valid || out_ready).
REQ-020 Accept (in_valid && in_ready): next cycle out_data = in_data XOR ks, out_valid=1; latency 1, throughput 1 beat/cycle.
REQ-021 out_valid && !out_ready: out_data, out_valid held stable; out_valid clears on handshake with no new accept.
REQ-022 resync=1 (cfg_en=0): LFSR[ch_sel] <= seed (zero→1) next cycle; no beat accepted that cycle.
REQ-023 cfg_en asserted mid-stream: pending output still drains; LFSRs frozen until reload (REQ-016).
REQ-024 heartbeat = bits [HB_DIV+2:HB_DIV] of free-running counter, wraps silently.
REQ-025 Encrypt and decrypt identical: same seed, same beat sequence restores plaintext.

Reset
REQ-026 rst_n=0 asynchronously: seeds 0, LFSRs 1, out_valid 0, out_data 0, cfg_o 0, heartbeat counter 0, load_pending 0.
REQ-027 Reset mid-beat discards in-flight output; first beat after release uses state 1 on every channel.

Structure
REQ-028 Package xor_cipher_pkg SHALL hold default POLY, width limits and the lfsr_step function.
REQ-029 Sub-module xor_lfsr_ch (seed reg, LFSR, W-step advance) SHALL be instantiated N_CH times.

Verification (M=32, N_CH=2, W=1)
REQ-030 Reset, seeds 0, ch0 beats in_data 0,0,0 -> out_data 1,1,0 (states 0x1, 0x80200003, 0xC0300002).
REQ-031 Shift 64 bits ch1=0xDEADBEEF ch0=0x00000001, shift 64 more zeros -> cfg_o emits 0xDEADBEEF then 0x00000001 MSB-first; in_ready=0 throughout.
REQ-032 out_ready=0 after one accepted beat -> in_ready=0, out_data stable 10 cycles; out_ready=1 -> one handshake, stream resumes gap-free.
REQ-033 Alternate ch0/ch1 beats then resync ch0 -> ch0 restarts at seed sequence, ch1 continues unperturbed.
REQ-034 Random 1000-beat plaintext through two instances with equal seeds chained -> output equals plaintext.
REQ-035 rst_n low mid-stream with out_valid=1 -> out_valid=0 immediately; post-release first ch0 bit with data 0 -> 1.
